// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame parser: sync byte, parser states and abort codes.
package uart_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hAA;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    LEN,
    PAYLOAD,
    CHK,
    HOLD
  } parser_state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_NONE    = 2'd0;
  localparam err_code_t ERR_CHK     = 2'd1;
  localparam err_code_t ERR_LEN     = 2'd2;
  localparam err_code_t ERR_TIMEOUT = 2'd3;

  // States in which a frame is partially assembled and the inter-byte timer runs.
  function automatic logic is_frame_state(input parser_state_t s);
    return (s == CMD) || (s == LEN) || (s == PAYLOAD) || (s == CHK);
  endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// Receiver-FIFO pop handshake plus the held-frame / payload-read interface to the command layer.
interface uart_frame_parser_if #(
  parameter int MAX_LEN = 16
);
  localparam int AW = $clog2(MAX_LEN);

  logic          fifo_empty;
  logic [7:0]    rx_data;
  logic          rx_read;
  logic          frame_valid;
  logic [7:0]    frame_cmd;
  logic [AW:0]   frame_len;
  logic [AW-1:0] pl_addr;
  logic [7:0]    pl_data;
  logic          frame_ack;
  logic          frame_err;
  logic [1:0]    err_code;
  logic [7:0]    drop_count;

  modport slave (
    input  fifo_empty, rx_data, pl_addr, frame_ack,
    output rx_read, frame_valid, frame_cmd, frame_len, pl_data,
           frame_err, err_code, drop_count
  );

  modport master (
    output fifo_empty, rx_data, pl_addr, frame_ack,
    input  rx_read, frame_valid, frame_cmd, frame_len, pl_data,
           frame_err, err_code, drop_count
  );

endinterface

// File: rtl/uart_byte_fetch.sv
// Pops one byte at a time from the receiver FIFO; the byte is presented one cycle after the pop.
module uart_byte_fetch (
  input  logic       clk,
  input  logic       enable,
  input  logic       i_fifo_empty,
  input  logic [7:0] i_rx_data,
  input  logic       i_want_byte,
  output logic       o_rx_read,
  output logic       o_byte_stb,
  output logic [7:0] o_byte_data
);

  logic r_fetch_pend;

  // A pop is never issued while the previous one is still waiting for its data.
  assign o_rx_read   = enable & i_want_byte & ~i_fifo_empty & ~r_fetch_pend;
  assign o_byte_stb  = r_fetch_pend;
  assign o_byte_data = i_rx_data;

  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      r_fetch_pend <= 1'b0;
    end else begin
      r_fetch_pend <= o_rx_read;
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Hunts for SYNC, assembles CMD/LEN/PAYLOAD/CHK frames, verifies them and holds accepted
// frames for the command layer until acknowledged.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int TIMEOUT_CYCLES = 704
) (
  input  logic                clk,
  input  logic                enable,
  uart_frame_parser_if.slave  bus
);

  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [8:0]    MAX_LEN_B = 9'(MAX_LEN);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  parser_state_t r_state;
  parser_state_t w_state_nxt;

  logic          w_want_byte;
  logic          w_rx_read;
  logic          w_byte_stb;
  logic [7:0]    w_byte;
  logic          w_take;
  logic          w_len_bad;
  logic          w_last;
  logic          w_tmo_hit;
  logic          w_abort;
  err_code_t     w_abort_code;
  logic          w_load_cmd;
  logic          w_load_len;
  logic          w_load_pl;
  logic          w_drop;

  logic [7:0]    r_cmd;
  logic [AW:0]   r_len;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_sum;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_frame_valid;
  logic          r_frame_err;
  err_code_t     r_err_code;
  logic [7:0]    r_drop_cnt;
  logic          r_discard;
  logic [7:0]    r_buf [MAX_LEN];

  uart_byte_fetch u_fetch (
    .clk          (clk),
    .enable       (enable),
    .i_fifo_empty (bus.fifo_empty),
    .i_rx_data    (bus.rx_data),
    .i_want_byte  (w_want_byte),
    .o_rx_read    (w_rx_read),
    .o_byte_stb   (w_byte_stb),
    .o_byte_data  (w_byte)
  );

  assign w_want_byte = (r_state != HOLD);
  // A byte popped on the same edge as an abort belongs to no frame and is dropped silently.
  assign w_take      = w_byte_stb & ~r_discard;
  assign w_len_bad   = (w_byte == 8'd0) || ({1'b0, w_byte} > MAX_LEN_B);
  assign w_last      = ({1'b0, r_idx} == (r_len - (AW+1)'(1)));
  assign w_tmo_hit   = is_frame_state(r_state) & ~w_byte_stb & (r_tmo_cnt == TMO_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_abort      = 1'b0;
    w_abort_code = ERR_NONE;
    w_load_cmd   = 1'b0;
    w_load_len   = 1'b0;
    w_load_pl    = 1'b0;
    w_drop       = 1'b0;
    if (w_take) begin
      case (r_state)
        IDLE: begin
          if (w_byte == SYNC_BYTE) w_state_nxt = CMD;
          else                     w_drop      = 1'b1;
        end
        CMD: begin
          w_load_cmd  = 1'b1;
          w_state_nxt = LEN;
        end
        LEN: begin
          if (w_len_bad) begin
            w_abort      = 1'b1;
            w_abort_code = ERR_LEN;
            w_state_nxt  = IDLE;
          end else begin
            w_load_len  = 1'b1;
            w_state_nxt = PAYLOAD;
          end
        end
        PAYLOAD: begin
          w_load_pl = 1'b1;
          if (w_last) w_state_nxt = CHK;
        end
        CHK: begin
          if (w_byte == r_sum) begin
            w_state_nxt = HOLD;
          end else begin
            w_abort      = 1'b1;
            w_abort_code = ERR_CHK;
            w_state_nxt  = IDLE;
          end
        end
        default: ;
      endcase
    end else if (w_tmo_hit) begin
      w_abort      = 1'b1;
      w_abort_code = ERR_TIMEOUT;
      w_state_nxt  = IDLE;
    end
    if ((r_state == HOLD) && bus.frame_ack) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge enable) begin
    if (!enable) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge enable) begin
    if (!enable) begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_err_code    <= ERR_NONE;
      r_drop_cnt    <= 8'd0;
      r_tmo_cnt     <= '0;
      r_discard     <= 1'b0;
      r_cmd         <= 8'd0;
      r_len         <= '0;
    end else begin
      r_frame_valid <= (w_state_nxt == HOLD);
      r_frame_err   <= w_abort;
      if (w_abort)    r_err_code <= w_abort_code;
      if (w_drop)     r_drop_cnt <= sat_inc8(r_drop_cnt);
      if (w_load_cmd) r_cmd      <= w_byte;
      if (w_load_len) r_len      <= w_byte[AW:0];
      if (w_byte_stb || !is_frame_state(w_state_nxt)) r_tmo_cnt <= '0;
      else                                            r_tmo_cnt <= r_tmo_cnt + TW'(1);
      if (w_byte_stb)                r_discard <= 1'b0;
      else if (w_abort && w_rx_read) r_discard <= 1'b1;
    end
  end

  // Checksum, index and payload storage carry no reset: they are reloaded by every frame.
  always_ff @(posedge clk) begin
    if (w_load_cmd) r_sum <= w_byte;
    if (w_load_len) begin
      r_sum <= r_sum + w_byte;
      r_idx <= '0;
    end
    if (w_load_pl) begin
      r_buf[r_idx] <= w_byte;
      r_sum        <= r_sum + w_byte;
      r_idx        <= r_idx + AW'(1);
    end
  end

  assign bus.rx_read     = w_rx_read;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_cmd   = r_cmd;
  assign bus.frame_len   = r_len;
  assign bus.pl_data     = r_buf[bus.pl_addr];
  assign bus.frame_err   = r_frame_err;
  assign bus.err_code    = r_err_code;
  assign bus.drop_count  = r_drop_cnt;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: a queue-based receiver FIFO feeds directed and random byte
// streams; a positional frame model predicts accepted frames, aborts and drop counts.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 704;

  logic clk = 1'b0;
  logic enable;
  always #5 clk = ~clk;

  uart_frame_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

  uart_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO)) dut (
    .clk    (clk),
    .enable (enable),
    .bus    (bus)
  );

  typedef struct {
    bit              is_err;
    logic [1:0]      code;
    logic [7:0]      cmd;
    int              len;
    logic [15:0][7:0] pl;
  } evt_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [7:0]  fq[$];
  logic [7:0]  chunk[$];
  int          pop_cyc[$];
  evt_t        expq[$];
  int          exp_drops  = 0;
  int          exp_errs   = 0;
  int          err_pulses = 0;
  int          err_wide   = 0;
  bit          err_prev   = 1'b0;
  bit          pop;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Receiver FIFO: a pop accepted on an edge delivers its byte just after that edge.
  initial begin
    bus.fifo_empty = 1'b1;
    bus.rx_data    = 8'h00;
    forever begin
      @(negedge clk);
      bus.fifo_empty = (fq.size() == 0);
      #1;
      pop = bus.rx_read;
      @(posedge clk);
      #1;
      if (pop && fq.size() > 0) begin
        bus.rx_data = fq.pop_front();
        pop_cyc.push_back(cyc);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus.frame_err === 1'b1) begin
      err_pulses++;
      if (err_prev) err_wide++;
    end
    err_prev = (bus.frame_err === 1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    chunk.push_back(b);
  endtask

  // Walks the byte stream frame by frame by position, independent of any state machine.
  task automatic ref_parse();
    int         i;
    int         n;
    int         len;
    logic [7:0] sum;
    evt_t       e;
    i = 0;
    n = chunk.size();
    while (i < n) begin
      if (chunk[i] != 8'hAA) begin
        if (exp_drops < 255) exp_drops++;
        i++;
      end else if (i + 2 >= n) begin
        i = n;
      end else begin
        e.is_err = 1'b0;
        e.code   = 2'd0;
        e.cmd    = chunk[i+1];
        e.pl     = '0;
        len      = int'(chunk[i+2]);
        e.len    = len;
        if (len == 0 || len > MAX_LEN) begin
          e.is_err = 1'b1;
          e.code   = 2'd2;
          expq.push_back(e);
          i += 3;
        end else if (i + 3 + len >= n) begin
          i = n;
        end else begin
          sum = chunk[i+1] + chunk[i+2];
          for (int k = 0; k < len; k++) begin
            e.pl[k] = chunk[i+3+k];
            sum     = sum + chunk[i+3+k];
          end
          if (chunk[i+3+len] != sum) begin
            e.is_err = 1'b1;
            e.code   = 2'd1;
          end
          expq.push_back(e);
          i += 4 + len;
        end
      end
    end
  endtask

  task automatic wait_evt(output int kind);
    kind = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (bus.frame_valid === 1'b1) begin
        kind = 1;
        return;
      end
      if (bus.frame_err === 1'b1) begin
        kind = 2;
        return;
      end
    end
  endtask

  task automatic do_ack();
    bus.frame_ack = 1'b1;
    tick();
    bus.frame_ack = 1'b0;
    check("valid_drop_on_ack", bus.frame_valid, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 4000 && fq.size() != 0; i++) tick();
    repeat (6) tick();
    check("fifo_drained", fq.size(), 0);
  endtask

  task automatic run_chunk();
    evt_t e;
    int   kind;
    ref_parse();
    chunk.delete();
    while (expq.size() > 0) begin
      e = expq.pop_front();
      wait_evt(kind);
      check("evt_kind", kind, e.is_err ? 2 : 1);
      if (e.is_err) exp_errs++;
      if (kind == 0) break;
      if (kind == 1) begin
        check("frame_cmd", bus.frame_cmd, e.cmd);
        check("frame_len", bus.frame_len, e.len);
        for (int a = 0; a < e.len; a++) begin
          bus.pl_addr = 4'(a);
          #1;
          check("pl_data", bus.pl_data, e.pl[a]);
        end
        do_ack();
      end else begin
        check("err_code", bus.err_code, e.code);
        check("valid_after_err", bus.frame_valid, 1'b0);
        tick();
        check("err_one_cycle", bus.frame_err, 1'b0);
      end
    end
    drain();
    check("drop_count", bus.drop_count, exp_drops);
    check("err_pulse_total", err_pulses, exp_errs);
  endtask

  task automatic gen_random(input int nframes);
    int         junk;
    int         kind;
    int         len;
    logic [7:0] b;
    logic [7:0] cmd;
    logic [7:0] sum;
    for (int f = 0; f < nframes; f++) begin
      junk = $urandom_range(0, 2);
      for (int j = 0; j < junk; j++) begin
        b = 8'($urandom_range(0, 254));
        if (b >= 8'hAA) b = b + 8'd1;
        push(b);
      end
      cmd  = 8'($urandom_range(0, 255));
      kind = $urandom_range(0, 7);
      push(8'hAA);
      push(cmd);
      if (kind == 7) begin
        if ($urandom_range(0, 1) == 0) push(8'h00);
        else                           push(8'($urandom_range(17, 255)));
      end else begin
        len = $urandom_range(1, MAX_LEN);
        push(8'(len));
        sum = cmd + 8'(len);
        for (int k = 0; k < len; k++) begin
          b   = 8'($urandom_range(0, 255));
          sum = sum + b;
          push(b);
        end
        if (kind == 6) sum = sum ^ 8'($urandom_range(1, 255));
        push(sum);
      end
    end
  endtask

  initial begin
    int   det;
    int   n_rd;
    int   n0;
    int   kind;
    int   ack_cyc;
    logic [7:0] b;

    enable        = 1'b0;
    bus.pl_addr   = '0;
    bus.frame_ack = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_frame_valid", bus.frame_valid, 1'b0);
    check("rst_frame_cmd",   bus.frame_cmd,   8'h00);
    check("rst_frame_len",   bus.frame_len,   5'd0);
    check("rst_frame_err",   bus.frame_err,   1'b0);
    check("rst_err_code",    bus.err_code,    2'd0);
    check("rst_drop_count",  bus.drop_count,  8'd0);
    check("rst_rx_read",     bus.rx_read,     1'b0);
    enable = 1'b1;
    tick();

    // Good frame, then junk before a frame, then bad checksum followed by a good frame.
    push(8'hAA); push(8'h10); push(8'h02); push(8'h01); push(8'h02); push(8'h15);
    run_chunk();
    push(8'h55); push(8'h00); push(8'hAA); push(8'h20); push(8'h01); push(8'h7F); push(8'hA0);
    run_chunk();
    check("drop_after_junk", bus.drop_count, 8'd2);
    push(8'hAA); push(8'h10); push(8'h02); push(8'h01); push(8'h02); push(8'h16);
    push(8'hAA); push(8'h10); push(8'h02); push(8'h01); push(8'h02); push(8'h15);
    run_chunk();
    check("chk_err_code", bus.err_code, 2'd1);
    push(8'hAA); push(8'h10); push(8'h00);
    push(8'hAA); push(8'h10); push(8'h11);
    run_chunk();
    check("len_err_code", bus.err_code, 2'd2);

    // Timeout: starve the FIFO after the first payload byte.
    fq.push_back(8'hAA); fq.push_back(8'h10); fq.push_back(8'h02); fq.push_back(8'h01);
    det = -1;
    for (int i = 0; i < TMO + 200; i++) begin
      tick();
      if (bus.frame_err === 1'b1) begin
        det = cyc;
        break;
      end
    end
    exp_errs++;
    check("tmo_seen", (det >= 0), 1'b1);
    check("tmo_latency", det - (pop_cyc[$] + 1), TMO);
    check("tmo_err_code", bus.err_code, 2'd3);
    check("tmo_valid", bus.frame_valid, 1'b0);
    tick();
    check("tmo_err_one_cycle", bus.frame_err, 1'b0);

    // Held frame blocks pops; after ack the queued bytes drain at one per two cycles.
    fq.push_back(8'hAA); fq.push_back(8'h40); fq.push_back(8'h01); fq.push_back(8'h33);
    fq.push_back(8'h74); fq.push_back(8'h55); fq.push_back(8'h66); fq.push_back(8'h77);
    wait_evt(kind);
    check("hold_evt", kind, 1);
    check("hold_cmd", bus.frame_cmd, 8'h40);
    check("hold_len", bus.frame_len, 5'd1);
    bus.pl_addr = 4'd0;
    #1;
    check("hold_pl0", bus.pl_data, 8'h33);
    n_rd = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.rx_read !== 1'b0) n_rd++;
    end
    check("hold_no_pop", n_rd, 0);
    check("hold_still_valid", bus.frame_valid, 1'b1);
    n0 = pop_cyc.size();
    bus.frame_ack = 1'b1;
    tick();
    ack_cyc = cyc;
    bus.frame_ack = 1'b0;
    check("hold_ack_drop", bus.frame_valid, 1'b0);
    repeat (10) tick();
    check("hold_pop_count", pop_cyc.size() - n0, 3);
    for (int i = 0; i < 3; i++) begin
      if (pop_cyc.size() > n0 + i) check("hold_pop_cycle", pop_cyc[n0+i], ack_cyc + 1 + 2*i);
    end
    exp_drops += 3;
    drain();
    check("hold_drops", bus.drop_count, exp_drops);

    // Random frames: good, corrupted checksum, illegal length, with junk in between.
    gen_random(10);
    run_chunk();
    gen_random(10);
    run_chunk();

    // Drop counter saturation, then a frame still parses.
    for (int i = 0; i < 300; i++) begin
      b = 8'($urandom_range(0, 254));
      if (b >= 8'hAA) b = b + 8'd1;
      push(b);
    end
    push(8'hAA); push(8'h21); push(8'h03); push(8'hFF); push(8'h80); push(8'h01); push(8'hA4);
    run_chunk();
    check("drop_saturated", bus.drop_count, 8'hFF);

    // Asynchronous reset in the middle of a payload.
    fq.push_back(8'hAA); fq.push_back(8'h30); fq.push_back(8'h05);
    fq.push_back(8'h01); fq.push_back(8'h02);
    repeat (9) tick();
    enable = 1'b0;
    #1;
    check("arst_frame_valid", bus.frame_valid, 1'b0);
    check("arst_frame_cmd",   bus.frame_cmd,   8'h00);
    check("arst_frame_len",   bus.frame_len,   5'd0);
    check("arst_frame_err",   bus.frame_err,   1'b0);
    check("arst_err_code",    bus.err_code,    2'd0);
    check("arst_drop_count",  bus.drop_count,  8'd0);
    check("arst_rx_read",     bus.rx_read,     1'b0);
    fq.delete();
    exp_drops = 0;
    tick();
    tick();
    enable = 1'b1;
    tick();
    push(8'h11);
    push(8'hAA); push(8'h10); push(8'h02); push(8'h01); push(8'h02); push(8'h15);
    run_chunk();
    check("err_single_cycle", err_wide, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
